pulse_conditioner: RTL and testbench
====================================

Name: pulse_conditioner

Overview:
Upstream conditioning stage for the timeout counter (counters_timeout). It takes a raw, asynchronous, possibly bouncing input, synchronises it to clk and debounces it. It then emits exactly one single-cycle `pulse` per accepted rising edge, and that pulse drives the counter's pulse input. A debounced level and a saturating count of rejected glitches are also exported for observability.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on raw_in; legal range is 2 or more.
DEBOUNCE_CYCLES, 4, consecutive synchronised samples needed to accept a level change; legal range is 2 to 65535.
GLITCH_W, 8, width of the saturating glitch counter.

Ports:
clk  input  1  single clock; all state is rising-edge triggered.
rst  input  1  asynchronous, active-high reset; clears all state immediately.
raw_in  input  1  asynchronous raw signal (switch or external line).
pulse  output  1  one-cycle strobe on each accepted rising edge; registered.
level  output  1  debounced level; registered.
glitch_cnt  output  GLITCH_W  count of aborted qualifications; saturates at all-ones.

Behaviour:
- Reset values: sync chain 0, state LOW, debounce counter 0, pulse 0, level 0, glitch_cnt 0. Reset takes effect asynchronously, mid-operation included; no pulse is produced during reset.
- Synchroniser: raw_in passes through SYNC_STAGES flops. `s` is the last flop's output. The FSM sees only `s`.
- Debounce counter width: CNT_W = $clog2(DEBOUNCE_CYCLES)+1.
- LOW (level=0):
  - s=1 -> go to RISE_WAIT, cnt=1.
  - Otherwise stay.
- RISE_WAIT (level=0):
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> go to HIGH; pulse<=1; level<=1; cnt=0.
  - s=1 otherwise -> cnt++.
  - s=0 -> go to LOW; cnt=0; glitch_cnt++ (saturating).
- HIGH (level=1):
  - s=0 -> go to FALL_WAIT, cnt=1.
- FALL_WAIT (level=1):
  - s=0 and cnt==DEBOUNCE_CYCLES-1 -> go to LOW; level<=0; cnt=0. No pulse is produced on a fall.
  - s=0 otherwise -> cnt++.
  - s=1 -> go to HIGH; cnt=0; glitch_cnt++ (saturating).
- pulse is high for exactly one cycle; it returns to 0 on the next edge unconditionally. Two pulses are always separated by at least 2*DEBOUNCE_CYCLES cycles.
- Latency: if raw_in rises between edge 0 and edge 1 and then stays stable, pulse and level rise at edge SYNC_STAGES+DEBOUNCE_CYCLES. With the defaults that is edge 6. Falling latency for level is identical.
- Raw_in high across reset release counts as a fresh rising edge: a pulse is produced SYNC_STAGES+DEBOUNCE_CYCLES edges after release.
- glitch_cnt holds at 2^GLITCH_W-1 once reached. It is cleared only by rst.
- Illegal states (unused encodings) recover to LOW with cnt=0 and no pulse.

Decomposition:
- Package pulse_conditioner_pkg:
  - 2-bit state encoding localparams ST_LOW, ST_RISE_WAIT, ST_HIGH, ST_FALL_WAIT.
  - CNT_W computation function.
- One sub-module, bit_synchronizer (parameter STAGES; ports clk, rst, d, q). It is reusable elsewhere in the codebase for other async inputs.
- FSM, debounce counter and glitch counter stay in the top module.

Test Plan:
All scenarios use the defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
1. rst=1 for 2 cycles, release, raw_in=1 held for 20 cycles -> pulse=1 for exactly one cycle, rising at edge 6 after raw_in rises; level=1 from the same edge onward; glitch_cnt=0.
2. From LOW, raw_in=1 for 2 cycles then 0 -> no pulse, level stays 0, glitch_cnt=1. Repeat 300 times -> glitch_cnt=255 and holds there.
3. From HIGH, raw_in=0 held -> level falls at edge 6 after the change; pulse stays 0 throughout.
4. From HIGH, raw_in=0 for 3 cycles then 1 -> level stays 1, glitch_cnt increments by 1, no pulse.
5. Five clean presses (raw_in 10 cycles high, 10 low), chained into counters_timeout -> exactly 5 one-cycle pulses; the downstream counter reads 5.
6. rst asserted asynchronously mid-clock while in RISE_WAIT -> pulse, level and glitch_cnt read 0 before the next edge. After release with raw_in held high -> one pulse at edge 6.

Source files
------------

// File: rtl/pulse_conditioner_pkg.sv
// Shared state encoding and sizing helper for the pulse conditioner.
package pulse_conditioner_pkg;

    localparam logic [1:0] ST_LOW       = 2'd0;
    localparam logic [1:0] ST_RISE_WAIT = 2'd1;
    localparam logic [1:0] ST_HIGH      = 2'd2;
    localparam logic [1:0] ST_FALL_WAIT = 2'd3;

    function automatic int unsigned cnt_w(input int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/pulse_conditioner.sv
// Synchronise and debounce a raw input; strobe once per accepted rising edge.
module pulse_conditioner
    import pulse_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw_in,
    output logic                pulse,
    output logic                level,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned      CNT_W    = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                w_s;
    logic [1:0]          r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic                r_pulse, w_pulse_next;
    logic                r_level, w_level_next;
    logic [GLITCH_W-1:0] r_glitch, w_glitch_next;
    logic                w_glitch_inc;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (w_s)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pulse_next = 1'b0;
        w_level_next = r_level;
        w_glitch_inc = 1'b0;
        case (r_state)
            ST_LOW: begin
                w_level_next = 1'b0;
                w_cnt_next   = '0;
                if (w_s) begin
                    w_state_next = ST_RISE_WAIT;
                    w_cnt_next   = CNT_ONE;
                end
            end
            ST_RISE_WAIT: begin
                if (!w_s) begin
                    w_state_next = ST_LOW;
                    w_cnt_next   = '0;
                    w_glitch_inc = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_HIGH;
                    w_cnt_next   = '0;
                    w_pulse_next = 1'b1;
                    w_level_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_HIGH: begin
                w_level_next = 1'b1;
                w_cnt_next   = '0;
                if (!w_s) begin
                    w_state_next = ST_FALL_WAIT;
                    w_cnt_next   = CNT_ONE;
                end
            end
            ST_FALL_WAIT: begin
                if (w_s) begin
                    w_state_next = ST_HIGH;
                    w_cnt_next   = '0;
                    w_glitch_inc = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_LOW;
                    w_cnt_next   = '0;
                    w_level_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_LOW;
                w_cnt_next   = '0;
                w_level_next = 1'b0;
            end
        endcase
    end

    // Saturate rather than wrap so a noisy line never reads as a quiet one.
    always_comb begin
        w_glitch_next = r_glitch;
        if (w_glitch_inc && (r_glitch != '1)) begin
            w_glitch_next = r_glitch + GLITCH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_LOW;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
            r_level  <= 1'b0;
            r_glitch <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_pulse  <= w_pulse_next;
            r_level  <= w_level_next;
            r_glitch <= w_glitch_next;
        end
    end

    assign pulse      = r_pulse;
    assign level      = r_level;
    assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed and random stimulus against a run-length debounce reference model.
module tb_pulse_conditioner;

    localparam int S = 2;
    localparam int D = 4;
    localparam int G = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         raw_in = 1'b0;
    logic         pulse;
    logic         level;
    logic [G-1:0] glitch_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: raw history delay line plus run length of disagreeing samples.
    logic [S-1:0] m_hist;
    logic         m_level;
    logic         m_pulse;
    int           m_run;
    int           m_glitch;

    pulse_conditioner #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .GLITCH_W        (G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .pulse      (pulse),
        .level      (level),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_hist   = '0;
        m_level  = 1'b0;
        m_pulse  = 1'b0;
        m_run    = 0;
        m_glitch = 0;
    endtask

    task automatic model_edge(input logic r);
        logic s;
        s       = m_hist[S-1];
        m_hist  = {m_hist[S-2:0], r};
        m_pulse = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == D) begin
                m_pulse = ~m_level;
                m_level = ~m_level;
                m_run   = 0;
            end
        end else if (m_run > 0) begin
            if (m_glitch < (1 << G) - 1) m_glitch++;
            m_run = 0;
        end
    endtask

    task automatic check_all();
        chk("pulse", 32'(pulse), 32'(m_pulse));
        chk("level", 32'(level), 32'(m_level));
        chk("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
    endtask

    task automatic step(input logic r);
        raw_in = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        check_all();
    endtask

    // Asserts rst between edges and checks outputs clear before the next edge.
    task automatic async_reset(input logic r);
        #2;
        rst    = 1'b1;
        raw_in = r;
        model_clear();
        #1;
        chk("rst_pulse", 32'(pulse), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_glitch", 32'(glitch_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int first;
        int npulse;
        int fall_at;
        logic r;
        int hold;

        model_clear();
        async_reset(1'b0);

        // Clean rise held high: one pulse at edge 6.
        first = -1;
        npulse = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1);
            if (pulse === 1'b1) begin
                npulse++;
                if (first < 0) first = k;
            end
        end
        chk("s1_pulse_edge", 32'(first), 32'd6);
        chk("s1_pulse_count", 32'(npulse), 32'd1);
        chk("s1_level", 32'(level), 32'd1);

        // Short low dip while HIGH is rejected.
        for (int k = 0; k < 3; k++) step(1'b0);
        for (int k = 0; k < 6; k++) step(1'b1);
        chk("s4_level", 32'(level), 32'd1);
        chk("s4_glitch", 32'(glitch_cnt), 32'd1);

        // Sustained low: level falls at edge 6, no pulse.
        fall_at = -1;
        npulse = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0);
            if (pulse === 1'b1) npulse++;
            if (level === 1'b0 && fall_at < 0) fall_at = k;
        end
        chk("s3_fall_edge", 32'(fall_at), 32'd6);
        chk("s3_no_pulse", 32'(npulse), 32'd0);

        // Repeated short highs saturate the glitch counter.
        npulse = 0;
        for (int n = 0; n < 300; n++) begin
            step(1'b1);
            step(1'b1);
            for (int k = 0; k < 4; k++) begin
                step(1'b0);
                if (pulse === 1'b1) npulse++;
            end
        end
        chk("s2_glitch_sat", 32'(glitch_cnt), 32'd255);
        chk("s2_no_pulse", 32'(npulse), 32'd0);
        chk("s2_level", 32'(level), 32'd0);

        // Five clean presses.
        npulse = 0;
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 10; k++) begin
                step(1'b1);
                if (pulse === 1'b1) npulse++;
            end
            for (int k = 0; k < 10; k++) begin
                step(1'b0);
                if (pulse === 1'b1) npulse++;
            end
        end
        chk("s5_press_count", 32'(npulse), 32'd5);
        chk("s5_glitch_hold", 32'(glitch_cnt), 32'd255);

        // Reset in the middle of rise qualification, then raw held high across release.
        for (int k = 0; k < 3; k++) step(1'b1);
        async_reset(1'b1);
        first = -1;
        npulse = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1);
            if (pulse === 1'b1) begin
                npulse++;
                if (first < 0) first = k;
            end
        end
        chk("s6_pulse_edge", 32'(first), 32'd6);
        chk("s6_pulse_count", 32'(npulse), 32'd1);

        // Random bouncing input.
        for (int n = 0; n < 600; n++) begin
            r    = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 7));
            for (int k = 0; k < hold; k++) step(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
